// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - Keccak geometry constants and theta-step FSM encoding
package keccak_pkg;

    localparam int ROW_SIZE  = 5;
    localparam int COL_SIZE  = 5;
    localparam int LANE_SIZE = 64;
    localparam int PLANE_CNT = 5;

    typedef enum logic {
        TH_LOAD,
        TH_DRAIN
    } theta_fsm_e;

endpackage

// File: rtl/theta_step_iter_if.sv
// rtl/theta_step_iter_if.sv - plane-serial input/output handshake bundle for theta_step_iter
interface theta_step_iter_if #(
    parameter int LANE_W = 64
);

    logic                                     in_valid_i;
    logic                                     in_ready_o;
    logic [keccak_pkg::ROW_SIZE*LANE_W-1:0]   in_plane_i;
    logic                                     in_bypass_i;
    logic                                     out_valid_o;
    logic                                     out_ready_i;
    logic [keccak_pkg::ROW_SIZE*LANE_W-1:0]   out_plane_o;
    logic [2:0]                               out_y_o;
    logic                                     busy_o;

    modport slave (
        input  in_valid_i, in_plane_i, in_bypass_i, out_ready_i,
        output in_ready_o, out_valid_o, out_plane_o, out_y_o, busy_o
    );

    modport master (
        output in_valid_i, in_plane_i, in_bypass_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_plane_o, out_y_o, busy_o
    );

endinterface

// File: rtl/theta_d_calc.sv
// rtl/theta_d_calc.sv - combinational theta D[x] = C[x-1] ^ ROL1(C[x+1]) from column parities
module theta_d_calc
    import keccak_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic [ROW_SIZE-1:0][LANE_W-1:0] c_i,
    output logic [ROW_SIZE-1:0][LANE_W-1:0] d_o
);

    // Rotate toward the MSB by one; the modulo form degenerates to identity for LANE_W=1.
    function automatic logic [LANE_W-1:0] rol1(input logic [LANE_W-1:0] v);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANE_W; i++) begin
            r[i] = v[(i + LANE_W - 1) % LANE_W];
        end
        return r;
    endfunction

    always_comb begin
        d_o = '0;
        for (int x = 0; x < ROW_SIZE; x++) begin
            d_o[x] = c_i[(x + ROW_SIZE - 1) % ROW_SIZE] ^ rol1(c_i[(x + 1) % ROW_SIZE]);
        end
    end

endmodule

// File: rtl/theta_step_iter.sv
// rtl/theta_step_iter.sv - plane-serial Keccak theta: load 5 planes accumulating parity, then drain 5 transformed planes
module theta_step_iter
    import keccak_pkg::*;
#(
    parameter int LANE_W = LANE_SIZE
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    theta_step_iter_if.slave   bus
);

    typedef logic [LANE_W-1:0]        lane_t;
    typedef lane_t [ROW_SIZE-1:0]     plane_t;

    localparam logic [2:0] LAST_Y = 3'(PLANE_CNT - 1);

    theta_fsm_e                 state_q, state_d;
    logic [2:0]                 in_cnt_q, in_cnt_d;
    logic [2:0]                 out_cnt_q, out_cnt_d;
    plane_t                     c_q, c_d;
    plane_t [PLANE_CNT-1:0]     state_buf_q, state_buf_d;
    logic                       bypass_q, bypass_d;
    plane_t                     d;
    plane_t                     in_plane;
    plane_t                     out_plane;
    logic                       in_fire;
    logic                       out_fire;

    assign in_plane = bus.in_plane_i;
    assign in_fire  = (state_q == TH_LOAD) && bus.in_valid_i;
    assign out_fire = (state_q == TH_DRAIN) && bus.out_ready_i;

    theta_d_calc #(.LANE_W(LANE_W)) u_d_calc (
        .c_i (c_q),
        .d_o (d)
    );

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        c_d         = c_q;
        state_buf_d = state_buf_q;
        bypass_d    = bypass_q;

        if (in_fire) begin
            state_buf_d[in_cnt_q] = in_plane;
            // The y=0 beat restarts parity so nothing leaks from a previous state.
            for (int x = 0; x < ROW_SIZE; x++) begin
                c_d[x] = (in_cnt_q == 3'd0) ? in_plane[x] : (c_q[x] ^ in_plane[x]);
            end
            if (in_cnt_q == 3'd0) begin
                bypass_d = bus.in_bypass_i;
            end
            if (in_cnt_q == LAST_Y) begin
                in_cnt_d = 3'd0;
                state_d  = TH_DRAIN;
            end else begin
                in_cnt_d = in_cnt_q + 3'd1;
            end
        end

        if (out_fire) begin
            if (out_cnt_q == LAST_Y) begin
                out_cnt_d = 3'd0;
                state_d   = TH_LOAD;
            end else begin
                out_cnt_d = out_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= TH_LOAD;
            in_cnt_q    <= 3'd0;
            out_cnt_q   <= 3'd0;
            c_q         <= '0;
            state_buf_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            c_q         <= c_d;
            state_buf_q <= state_buf_d;
            bypass_q    <= bypass_d;
        end
    end

    always_comb begin
        out_plane = '0;
        if (state_q == TH_DRAIN) begin
            for (int x = 0; x < ROW_SIZE; x++) begin
                out_plane[x] = state_buf_q[out_cnt_q][x] ^ (bypass_q ? lane_t'(0) : d[x]);
            end
        end
    end

    assign bus.in_ready_o  = (state_q == TH_LOAD);
    assign bus.out_valid_o = (state_q == TH_DRAIN);
    assign bus.out_plane_o = out_plane;
    assign bus.out_y_o     = out_cnt_q;
    assign bus.busy_o      = (state_q != TH_LOAD) || (in_cnt_q != 3'd0);

endmodule

// File: doc/theta_step_iter.md
Name: theta_step_iter

Overview:
- Plane-serial, handshaked implementation of the Keccak theta step, parametrised in lane width so one block serves Keccak-f[25..1600].
- Accepts the state one plane (5 lanes, fixed y) per beat and accumulates the column parities while buffering the state.
- Then emits the theta-transformed state one plane per beat.
- Sits between the state register/absorb path and the rho/pi stages in area-constrained round pipelines; supports a bypass mode.

Parameters:
- LANE_W, 64, lane width w in bits; legal values 1,2,4,8,16,32,64. ROW_SIZE = COL_SIZE = 5 come from keccak_pkg.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  input plane valid
- in_ready_o  output  1  block can accept a plane
- in_plane_i  input  ROW_SIZE*LANE_W  lanes x=0..4 of plane y; lane x at bits [x*LANE_W +: LANE_W]
- in_bypass_i  input  1  sampled on the y=0 input beat; 1 = output equals input (theta disabled)
- out_valid_o  output  1  output plane valid
- out_ready_i  input  1  downstream accepts plane
- out_plane_o  output  ROW_SIZE*LANE_W  transformed lanes x=0..4 of plane out_y_o
- out_y_o  output  3  y index of out_plane_o, 0..4
- busy_o  output  1  high whenever the FSM is not in LOAD or the input counter is nonzero

Behaviour:
- Reset (async, rst_ni low):
  - State = LOAD.
  - In counter = 0, out counter = 0.
  - Parity regs C[0..4] = 0, state buffer = 0, bypass flag = 0.
  - Outputs: out_valid_o = 0, out_y_o = 0, out_plane_o = 0, busy_o = 0, in_ready_o = 1. in_ready_o is 1 immediately after reset, since it is decoded from state.
- FSM states: LOAD, DRAIN. The FSM state type is an enum in keccak_pkg.
- LOAD:
  - in_ready_o = 1 and out_valid_o = 0.
  - On in_valid_i & in_ready_o, with y = in counter:
    - buf[y][x] <= lane x;
    - C[x] <= C[x] ^ lane x (on y=0, C[x] <= lane x, discarding stale parity);
    - on y=0, the bypass flag <= in_bypass_i;
    - in counter++.
  - On acceptance of y=4: in counter <= 0 and go to DRAIN.
- DRAIN:
  - in_ready_o = 0, out_valid_o = 1, out_y_o = out counter.
  - D[x] = C[(x+4)%5] ^ ROL1(C[(x+1)%5]). ROL1 is a rotate toward the MSB within LANE_W; bit w-1 wraps to bit 0. For LANE_W=1, ROL1 is the identity.
  - out_plane_o lane x = buf[out_y][x] ^ D[x], or buf[out_y][x] if the bypass flag is set.
  - On out_ready_i: out counter++. At y=4 handshake: out counter <= 0 and go to LOAD.
- Latency: the first output plane is valid in the cycle after the 5th input beat is accepted. Minimum 10 cycles per state; load and drain do not overlap.
- Backpressure: while out_valid_o & !out_ready_i, out_plane_o and out_y_o hold stable.
- Gaps: in_valid_i deasserted mid-load leaves counters and parity unchanged. There is no timeout.
- in_plane_i and in_bypass_i are ignored when in_ready_o = 0.
- Reset mid-operation: the partial state is discarded, all registers take their reset values, and no output beat is emitted for the aborted state.
- All arithmetic is XOR/rotate; there is no carry. Counters are 3-bit and never exceed 4.

Decomposition:
- keccak_pkg (existing): ROW_SIZE, COL_SIZE, LANE_SIZE.
- Add to keccak_pkg: the theta_fsm_e enum {TH_LOAD, TH_DRAIN} and localparam PLANE_CNT = 5.
- Lane-width-dependent types are declared locally from LANE_W.
- One combinational sub-module, theta_d_calc (parameter LANE_W): input C[0..4], output D[0..4]. It is reused by future plane-serial round units.

Test Plan:
- LANE_W=64, single bit: plane y=0 lane x=0 = 0x1, all other lanes 0, out_ready_i=1.
  - Outputs y=0: x0=0x1, x1=0x1, x4=0x2, other lanes 0.
  - Outputs y=1..4: x1=0x1, x4=0x2, other lanes 0.
  - First out_valid_o is one cycle after the 5th input beat.
- LANE_W=8, wrap: lane (0,0) = 0x80, rest 0 -> D[1]=0x80, D[4]=0x01. Every plane has x4=0x01; plane 0 has x0=0x80 and x1=0x80.
- All lanes = all-ones (LANE_W=64) -> C[x]=all-ones, D=0, every output lane = 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: hold out_ready_i=0 for 3 cycles at out_y_o=2 -> out_plane_o and out_y_o=2 stable, in_ready_o=0. Then release -> y=3,4 follow and in_ready_o=1 the cycle after the y=4 handshake.
- Bypass: in_bypass_i=1 on the y=0 beat with the single-bit pattern -> output equals input exactly. A second state with bypass=0 gets the normal theta result (the stale flag is not reused).
- Reset mid-drain: assert rst_ni low at out_y_o=2 -> out_valid_o=0 immediately (async), in_ready_o=1 after release. Then load the single-bit pattern -> expected result identical to the first test (no stale parity).
